// File: rtl/mdu_pkg.sv
// mdu_pkg: shared MD opcode encodings and default latencies
package mdu_pkg;
  localparam int MDOP_W = 3;
  localparam logic [MDOP_W-1:0] MDOP_NONE  = 3'd0;
  localparam logic [MDOP_W-1:0] MDOP_MULT  = 3'd1;
  localparam logic [MDOP_W-1:0] MDOP_MULTU = 3'd2;
  localparam logic [MDOP_W-1:0] MDOP_DIV   = 3'd3;
  localparam logic [MDOP_W-1:0] MDOP_DIVU  = 3'd4;
  localparam logic [MDOP_W-1:0] MDOP_MTHI  = 3'd5;
  localparam logic [MDOP_W-1:0] MDOP_MTLO  = 3'd6;
  localparam logic [MDOP_W-1:0] MDOP_RSVD  = 3'd7;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational mult/div result as {hi,lo} plus div-by-zero flag
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  input  logic [MDOP_W-1:0] mdop,
  output logic [63:0]       res,
  output logic              dz
);
  logic [31:0] bs;
  logic signed [63:0] sp;
  logic [63:0] up;
  logic signed [31:0] sq, sr;
  assign dz = (b == 32'd0) && (mdop == MDOP_DIV || mdop == MDOP_DIVU);
  assign bs = (b == 32'd0) ? 32'd1 : b;
  assign sp = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign up = {32'd0, a} * {32'd0, b};
  assign sq = $signed(a) / $signed(bs);
  assign sr = $signed(a) % $signed(bs);
  assign res = (mdop == MDOP_MULT)  ? sp :
               (mdop == MDOP_MULTU) ? up :
               (mdop == MDOP_DIV)   ? {sr, sq} :
                                      {a % bs, a / bs};
endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: EX-stage multiply/divide unit owning HI/LO with a busy countdown
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  input  logic [MDOP_W-1:0] mdop,
  input  logic              start,
  output logic [31:0]       hi,
  output logic [31:0]       lo,
  output logic              busy,
  output logic              md_stall
);
  logic [CNT_W-1:0] cnt;
  logic [63:0] pend, res;
  logic pend_dz, dz, is_md, is_div;
  mdu_calc u_calc (.a(a), .b(b), .mdop(mdop), .res(res), .dz(dz));
  assign is_md    = (mdop >= MDOP_MULT) && (mdop <= MDOP_DIVU);
  assign is_div   = (mdop == MDOP_DIV) || (mdop == MDOP_DIVU);
  assign busy     = (cnt != '0);
  assign md_stall = busy | (start & is_md);
  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      pend    <= '0;
      pend_dz <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1) && !pend_dz) {hi, lo} <= pend;
    end else if (start) begin
      if (is_md) begin
        pend    <= res;
        pend_dz <= dz;
        cnt     <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (mdop == MDOP_MTHI) hi <= a;
      else if (mdop == MDOP_MTLO) lo <= a;
    end
  end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed and random checks of mdu_unit against an arithmetic model
module tb_mdu_unit;
  import mdu_pkg::*;
  localparam int MC = 5;
  localparam int DC = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [2:0] mdop = '0;
  logic start = 1'b0;
  logic [31:0] hi, lo;
  logic busy, md_stall;
  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .mdop(mdop), .start(start),
    .hi(hi), .lo(lo), .busy(busy), .md_stall(md_stall)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (!reset) assert (!(start && busy)) else begin
      failures++;
      $error("FAIL start_while_busy got=1 exp=0");
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, mq, q, r;
    logic [63:0] p;
    if (op == 3'd1) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      p = 64'(sx * sy);
      return p;
    end
    if (op == 3'd2) begin
      p = 64'(longint'({32'd0, x}) * longint'({32'd0, y}));
      return p;
    end
    if (y == 32'd0) return {m_hi, m_lo};
    if (op == 3'd3) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      mq = (sx < 0 ? -sx : sx) / (sy < 0 ? -sy : sy);
      q = ((sx < 0) != (sy < 0)) ? -mq : mq;
      r = sx - q * sy;
    end else begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
      q = sx / sy;
      r = sx - q * sy;
    end
    p = {r[31:0], q[31:0]};
    return p;
  endfunction
  task automatic do_md(input string tag, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] e;
    int n;
    e = model(op, x, y);
    n = (op >= 3'd3) ? DC : MC;
    a = x;
    b = y;
    mdop = op;
    start = 1'b1;
    #1;
    chk({tag, "_stall0"}, {31'd0, md_stall}, 32'd1);
    step();
    start = 1'b0;
    mdop = 3'd0;
    a = $urandom;
    b = $urandom;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_stall"}, {31'd0, md_stall}, 32'd1);
      chk({tag, "_hold_hi"}, hi, m_hi);
      chk({tag, "_hold_lo"}, lo, m_lo);
      step();
    end
    m_hi = e[63:32];
    m_lo = e[31:0];
    chk({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, hi, m_hi);
    chk({tag, "_lo"}, lo, m_lo);
  endtask
  task automatic do_mt(input string tag, input logic [2:0] op, input logic [31:0] x);
    a = x;
    mdop = op;
    start = 1'b1;
    #1;
    chk({tag, "_stall"}, {31'd0, md_stall}, 32'd0);
    step();
    start = 1'b0;
    mdop = 3'd0;
    if (op == 3'd5) m_hi = x;
    else if (op == 3'd6) m_lo = x;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, hi, m_hi);
    chk({tag, "_lo"}, lo, m_lo);
  endtask
  initial begin
    logic [2:0] op;
    logic [31:0] x, y;
    step();
    step();
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, md_stall}, 32'd0);
    reset = 1'b0;
    do_md("mult", 3'd1, 32'hFFFFFFFF, 32'h2);
    chk("mult_hi_const", hi, 32'hFFFFFFFF);
    chk("mult_lo_const", lo, 32'hFFFFFFFE);
    do_md("multu", 3'd2, 32'hFFFFFFFF, 32'h2);
    chk("multu_hi_const", hi, 32'h00000001);
    chk("multu_lo_const", lo, 32'hFFFFFFFE);
    do_md("div", 3'd3, 32'hFFFFFFF9, 32'h2);
    chk("div_hi_const", hi, 32'hFFFFFFFF);
    chk("div_lo_const", lo, 32'hFFFFFFFD);
    do_md("divu", 3'd4, 32'hFFFFFFF9, 32'h2);
    chk("divu_hi_const", hi, 32'h00000001);
    chk("divu_lo_const", lo, 32'h7FFFFFFC);
    do_mt("pre_hi", 3'd5, 32'h11111111);
    do_mt("pre_lo", 3'd6, 32'h22222222);
    do_md("divu0", 3'd4, 32'h7, 32'h0);
    chk("divu0_hi_const", hi, 32'h11111111);
    chk("divu0_lo_const", lo, 32'h22222222);
    do_md("div0", 3'd3, 32'h7, 32'h0);
    do_mt("mthi", 3'd5, 32'hDEADBEEF);
    do_mt("mtlo", 3'd6, 32'h12345678);
    chk("mt_hi_kept", hi, 32'hDEADBEEF);
    do_mt("rsvd", 3'd7, 32'hCAFEF00D);
    do_mt("none", 3'd0, 32'hCAFEF00D);
    a = 32'd100;
    b = 32'd7;
    mdop = 3'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    mdop = 3'd0;
    step();
    reset = 1'b1;
    chk("rstmid_busy_before", {31'd0, busy}, 32'd1);
    step();
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);
    for (int i = 0; i < DC + 2; i++) step();
    chk("rstmid_nocommit_hi", hi, 32'd0);
    chk("rstmid_nocommit_lo", lo, 32'd0);
    do_md("mult_after_rst", 3'd1, 32'h00012345, 32'hFFFF0000);
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 6));
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (op == 3'd3 && x == 32'h80000000 && y == 32'hFFFFFFFF) y = 32'd3;
      if (op >= 3'd5) do_mt("rnd_mt", op, x);
      else do_md("rnd_md", op, x, y);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
